imem_loader: RTL and testbench

//  Writer side of the instruction memory: receives a program image as a byte stream
//  (e.g. from a UART receiver) and writes it word by word into the IMEM write port.

---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/loader_timeout.sv | 30 +++
 rtl/imem_loader.sv | 136 +++++++++++++
 tb/tb_imem_loader.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared state encoding and error codes for the IMEM loader
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

endpackage

// File: rtl/loader_timeout.sv
// rtl/loader_timeout.sv - idle-cycle watchdog between accepted bytes of a load
module loader_timeout #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] LIMIT = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [TW-1:0] timer;

    // The counter only runs while a byte is awaited; any other cycle parks it at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (clear || !enable) begin
            timer <= '0;
        end else if (timer != LIMIT) begin
            timer <= timer + 1'b1;
        end
    end

    assign expired = (TIMEOUT_CYCLES != 0) && enable && !clear && (timer == LIMIT);

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream program loader writing words into IMEM and gating core reset
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH          = 256,
    parameter int AW             = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          imem_we,
    output logic [AW-1:0] imem_waddr,
    output logic [31:0]   imem_wdata,
    output logic          cpu_rst_n,
    output logic          busy,
    output logic          done,
    output logic [1:0]    err_code,
    output logic [AW:0]   words_loaded
);

    state_t      state, state_nxt;
    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [15:0] len_in;
    logic [1:0]  byte_idx;
    logic [23:0] word_buf;
    logic        accept;
    logic        start_ok;
    logic        expired;
    logic        len_bad;
    logic        all_written;

    assign len_in      = {in_data, len_lo};
    assign len_bad     = (len_in == 16'd0) || ({16'd0, len_in} > 32'(DEPTH));
    assign all_written = (32'(words_loaded) == 32'(len));

    // After the final word is strobed the loader stops taking bytes for its last DATA cycle.
    assign in_ready = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                      ((state == S_DATA) && !all_written);
    assign busy     = (state == S_LEN_LO) || (state == S_LEN_HI) || (state == S_DATA);
    assign done     = (state == S_DONE);
    assign accept   = in_valid && in_ready;
    assign start_ok = start && (state == S_IDLE);

    loader_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (accept || start_ok),
        .enable (in_ready),
        .expired(expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_LEN_LO;
            S_LEN_LO: begin
                if (expired)     state_nxt = S_ERR;
                else if (accept) state_nxt = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (expired)     state_nxt = S_ERR;
                else if (accept) state_nxt = len_bad ? S_ERR : S_DATA;
            end
            S_DATA: begin
                if (all_written)  state_nxt = S_DONE;
                else if (expired) state_nxt = S_ERR;
            end
            S_DONE:   state_nxt = S_IDLE;
            S_ERR:    state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_we      <= 1'b0;
            imem_waddr   <= '0;
            imem_wdata   <= '0;
            cpu_rst_n    <= 1'b1;
            err_code     <= ERR_NONE;
            words_loaded <= '0;
            byte_idx     <= '0;
            word_buf     <= '0;
            len_lo       <= '0;
            len          <= '0;
        end else begin
            imem_we <= 1'b0;
            if (start_ok) begin
                cpu_rst_n    <= 1'b0;
                err_code     <= ERR_NONE;
                words_loaded <= '0;
                byte_idx     <= '0;
            end
            if (state == S_LEN_LO && accept) begin
                len_lo <= in_data;
            end
            if (state == S_LEN_HI && accept) begin
                len <= len_in;
                if (len_bad) err_code <= ERR_LEN;
            end
            if (expired) begin
                err_code <= ERR_TIMEOUT;
            end
            // Bytes shift in from the top so the first byte ends up in the low lane.
            if (state == S_DATA && accept) begin
                byte_idx <= byte_idx + 1'b1;
                word_buf <= {in_data, word_buf[23:8]};
                if (byte_idx == 2'd3) begin
                    imem_we      <= 1'b1;
                    imem_waddr   <= words_loaded[AW-1:0];
                    imem_wdata   <= {in_data, word_buf};
                    words_loaded <= words_loaded + 1'b1;
                end
            end
            if (state_nxt == S_DONE) begin
                cpu_rst_n <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

    localparam int DEPTH = 256;
    localparam int AW    = 8;
    localparam int TO    = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic          cpu_rst_n;
    logic          busy;
    logic          done;
    logic [1:0]    err_code;
    logic [AW:0]   words_loaded;

    int errors = 0;
    int checks = 0;
    int wr_count = 0;
    int wr_bad_addr = 0;
    int done_cnt = 0;
    logic [31:0] wmem [0:DEPTH-1];

    imem_loader #(
        .DEPTH(DEPTH),
        .AW(AW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .imem_we     (imem_we),
        .imem_waddr  (imem_waddr),
        .imem_wdata  (imem_wdata),
        .cpu_rst_n   (cpu_rst_n),
        .busy        (busy),
        .done        (done),
        .err_code    (err_code),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    // IMEM model: records each write strobe; addresses of one load must run 0,1,2,...
    always @(negedge clk) begin
        if (imem_we) begin
            if (32'(imem_waddr) != wr_count) wr_bad_addr++;
            wmem[imem_waddr] = imem_wdata;
            wr_count++;
        end
        if (done) done_cnt++;
    end

    function automatic logic [31:0] word_of(input int k);
        logic [7:0] b;
        b = 8'(k);
        return 32'h13579BDF ^ {b, ~b, b, 8'(k * 7)};
    endfunction

    task automatic clear_mon;
        wr_count = 0;
        wr_bad_addr = 0;
        done_cnt = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_byte_%02h: in_ready=%b, required 1 within 40 cycles", b, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
        send_byte(w[23:16]);
        send_byte(w[31:24]);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, imem_we, cpu_rst_n, busy, done} !== 5'b00100) begin
            errors++;
            $display("FAIL reset_ctrl: {rdy,we,cpu_rst_n,busy,done}=%b, required 00100",
                     {in_ready, imem_we, cpu_rst_n, busy, done});
        end
        checks++;
        if ({imem_waddr, imem_wdata, err_code, words_loaded} !== '0) begin
            errors++;
            $display("FAIL reset_data: waddr=%h wdata=%h err=%0d words=%0d, required all 0",
                     imem_waddr, imem_wdata, err_code, words_loaded);
        end
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_basic;
        logic [7:0] v [10];
        v = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
        clear_mon();
        pulse_start();
        checks++;
        if ({busy, cpu_rst_n, in_ready, err_code} !== 5'b10100) begin
            errors++;
            $display("FAIL basic_start: {busy,cpu_rst_n,rdy,err}=%b, required 10100",
                     {busy, cpu_rst_n, in_ready, err_code});
        end
        for (int i = 0; i < 10; i++) send_byte(v[i]);
        checks++;
        if ({imem_we, imem_waddr, imem_wdata, cpu_rst_n} !== {1'b1, 8'd1, 32'h00100593, 1'b0}) begin
            errors++;
            $display("FAIL basic_last_write: we=%b addr=%0d data=%h cpu_rst_n=%b, required 1 1 00100593 0",
                     imem_we, imem_waddr, imem_wdata, cpu_rst_n);
        end
        idle(1);
        checks++;
        if ({done, busy, cpu_rst_n, imem_we, words_loaded} !== {4'b1010, 9'd2}) begin
            errors++;
            $display("FAIL basic_done: done=%b busy=%b cpu_rst_n=%b we=%b words=%0d, required 1 0 1 0 2",
                     done, busy, cpu_rst_n, imem_we, words_loaded);
        end
        idle(2);
        checks++;
        if (wr_count != 2 || wr_bad_addr != 0 || wmem[0] !== 32'h00A00513 || wmem[1] !== 32'h00100593) begin
            errors++;
            $display("FAIL basic_mem: writes=%0d badaddr=%0d m0=%h m1=%h, required 2 0 00a00513 00100593",
                     wr_count, wr_bad_addr, wmem[0], wmem[1]);
        end
        checks++;
        if (done_cnt != 1 || err_code !== 2'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL basic_after: done_pulses=%0d err=%0d done=%b, required 1 0 0",
                     done_cnt, err_code, done);
        end
    endtask

    task automatic test_bad_len(input logic [7:0] lo, input logic [7:0] hi);
        clear_mon();
        pulse_start();
        checks++;
        if (err_code !== 2'd0 || cpu_rst_n !== 1'b0) begin
            errors++;
            $display("FAIL badlen_%02h%02h_start: err=%0d cpu_rst_n=%b, required 0 0", hi, lo, err_code, cpu_rst_n);
        end
        send_byte(lo);
        send_byte(hi);
        checks++;
        if ({err_code, busy, cpu_rst_n, in_ready} !== 5'b01000) begin
            errors++;
            $display("FAIL badlen_%02h%02h_err: {err,busy,cpu_rst_n,rdy}=%b, required 01000",
                     hi, lo, {err_code, busy, cpu_rst_n, in_ready});
        end
        idle(3);
        checks++;
        if (err_code !== 2'd1 || cpu_rst_n !== 1'b0 || wr_count != 0 || done_cnt != 0) begin
            errors++;
            $display("FAIL badlen_%02h%02h_sticky: err=%0d cpu_rst_n=%b writes=%0d dones=%0d, required 1 0 0 0",
                     hi, lo, err_code, cpu_rst_n, wr_count, done_cnt);
        end
    endtask

    task automatic test_full_depth;
        int bad;
        clear_mon();
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h01);
        for (int k = 0; k < DEPTH; k++) send_word(word_of(k));
        checks++;
        if ({imem_we, imem_waddr, imem_wdata} !== {1'b1, 8'd255, word_of(255)}) begin
            errors++;
            $display("FAIL full_last_write: we=%b addr=%0d data=%h, required 1 255 %h",
                     imem_we, imem_waddr, imem_wdata, word_of(255));
        end
        idle(1);
        checks++;
        if (done !== 1'b1 || words_loaded !== 9'd256 || cpu_rst_n !== 1'b1) begin
            errors++;
            $display("FAIL full_done: done=%b words=%0d cpu_rst_n=%b, required 1 256 1",
                     done, words_loaded, cpu_rst_n);
        end
        idle(2);
        bad = 0;
        for (int k = 0; k < DEPTH; k++) if (wmem[k] !== word_of(k)) bad++;
        checks++;
        if (wr_count != 256 || wr_bad_addr != 0 || bad != 0 || done_cnt != 1) begin
            errors++;
            $display("FAIL full_mem: writes=%0d badaddr=%0d baddata=%0d dones=%0d, required 256 0 0 1",
                     wr_count, wr_bad_addr, bad, done_cnt);
        end
    endtask

    task automatic test_timeout;
        clear_mon();
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        idle(15);
        checks++;
        if (err_code !== 2'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early: err=%0d busy=%b at idle cycle 16, required 0 1", err_code, busy);
        end
        idle(1);
        checks++;
        if ({err_code, busy, cpu_rst_n, in_ready} !== 5'b10000) begin
            errors++;
            $display("FAIL timeout_err: {err,busy,cpu_rst_n,rdy}=%b, required 10000",
                     {err_code, busy, cpu_rst_n, in_ready});
        end
        idle(2);
        checks++;
        if (wr_count != 0 || words_loaded !== 9'd0 || err_code !== 2'd2) begin
            errors++;
            $display("FAIL timeout_partial: writes=%0d words=%0d err=%0d, required 0 0 2",
                     wr_count, words_loaded, err_code);
        end
        clear_mon();
        pulse_start();
        checks++;
        if (err_code !== 2'd0) begin
            errors++;
            $display("FAIL timeout_clear: err=%0d, required 0", err_code);
        end
        send_byte(8'h01);
        send_byte(8'h00);
        send_word(32'hDEADBEEF);
        checks++;
        if (imem_we !== 1'b1 || imem_wdata !== 32'hDEADBEEF || imem_waddr !== 8'd0) begin
            errors++;
            $display("FAIL timeout_reload_write: we=%b addr=%0d data=%h, required 1 0 deadbeef",
                     imem_we, imem_waddr, imem_wdata);
        end
        idle(1);
        checks++;
        if (done !== 1'b1 || cpu_rst_n !== 1'b1 || err_code !== 2'd0) begin
            errors++;
            $display("FAIL timeout_reload_done: done=%b cpu_rst_n=%b err=%0d, required 1 1 0",
                     done, cpu_rst_n, err_code);
        end
        idle(2);
    endtask

    task automatic test_gaps;
        logic [31:0] w [3];
        w = '{32'h00000013, 32'h00500093, 32'hFFF00113};
        clear_mon();
        in_valid = 1'b1;
        in_data  = 8'h55;
        idle(3);
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || wr_count != 0) begin
            errors++;
            $display("FAIL gaps_idle_bytes: rdy=%b busy=%b writes=%0d, required 0 0 0", in_ready, busy, wr_count);
        end
        in_valid = 1'b0;
        pulse_start();
        send_byte(8'h03);
        send_byte(8'h00);
        send_word(w[0]);
        pulse_start();
        checks++;
        if (busy !== 1'b1 || words_loaded !== 9'd1 || cpu_rst_n !== 1'b0) begin
            errors++;
            $display("FAIL gaps_mid_start: busy=%b words=%0d cpu_rst_n=%b, required 1 1 0",
                     busy, words_loaded, cpu_rst_n);
        end
        for (int i = 0; i < 8; i++) begin
            idle(1 + (i % 5));
            send_byte(w[1 + i / 4][8 * (i % 4) +: 8]);
        end
        checks++;
        if (imem_we !== 1'b1 || imem_waddr !== 8'd2 || imem_wdata !== 32'hFFF00113) begin
            errors++;
            $display("FAIL gaps_last_write: we=%b addr=%0d data=%h, required 1 2 fff00113",
                     imem_we, imem_waddr, imem_wdata);
        end
        idle(1);
        checks++;
        if (done !== 1'b1 || words_loaded !== 9'd3) begin
            errors++;
            $display("FAIL gaps_done: done=%b words=%0d, required 1 3", done, words_loaded);
        end
        idle(2);
        checks++;
        if (wr_count != 3 || wr_bad_addr != 0 || wmem[0] !== w[0] || wmem[1] !== w[1] ||
            wmem[2] !== w[2] || done_cnt != 1 || err_code !== 2'd0) begin
            errors++;
            $display("FAIL gaps_mem: writes=%0d badaddr=%0d m0=%h m1=%h m2=%h dones=%0d err=%0d, required 3 0 %h %h %h 1 0",
                     wr_count, wr_bad_addr, wmem[0], wmem[1], wmem[2], done_cnt, err_code, w[0], w[1], w[2]);
        end
    endtask

    task automatic test_reset_mid;
        clear_mon();
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h00);
        send_word(32'h12345678);
        send_byte(8'hAA);
        send_byte(8'hBB);
        checks++;
        if (words_loaded !== 9'd1 || busy !== 1'b1 || imem_wdata !== 32'h12345678) begin
            errors++;
            $display("FAIL rstmid_pre: words=%0d busy=%b wdata=%h, required 1 1 12345678",
                     words_loaded, busy, imem_wdata);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, imem_we, cpu_rst_n, busy, done} !== 5'b00100) begin
            errors++;
            $display("FAIL rstmid_ctrl: {rdy,we,cpu_rst_n,busy,done}=%b, required 00100",
                     {in_ready, imem_we, cpu_rst_n, busy, done});
        end
        checks++;
        if ({imem_waddr, imem_wdata, err_code, words_loaded} !== '0) begin
            errors++;
            $display("FAIL rstmid_data: waddr=%h wdata=%h err=%0d words=%0d, required all 0",
                     imem_waddr, imem_wdata, err_code, words_loaded);
        end
        checks++;
        if (wmem[0] !== 32'h12345678 || wr_count != 1) begin
            errors++;
            $display("FAIL rstmid_mem: m0=%h writes=%0d, required 12345678 1", wmem[0], wr_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded 200000 time units, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_bad_len(8'h00, 8'h00);
        test_bad_len(8'h01, 8'h01);
        test_full_depth();
        test_timeout();
        test_gaps();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
